// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: fwd_sel_e (EX operand mux select), hz_state_e (stall engine
// state), REG_ZERO (hard-wired zero register index), sat_add32 helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_e;

    // Prefixed so the state names never collide with the LOAD_STALL parameter.
    typedef enum logic [1:0] {
        HZ_IDLE       = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MC_BUSY    = 2'd2
    } hz_state_e;

    localparam int REG_ZERO = 0;

    // 32-bit saturating accumulate of a small increment.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [2:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {30'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_lane.sv
// Forwarding select for one EX source operand.
// Latency: combinational.
// Backpressure: none; pure decode of pipeline register fields.
//
// Ports: rs (source index in ID/EX), ex_mem_rd/regwrite, mem_wb_rd/regwrite,
// sel (FWD_MEM beats FWD_WB beats FWD_RF; register zero never forwards).
module fwd_sel_lane
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    output fwd_sel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_mem_regwrite && (ex_mem_rd != REG_AW'(REG_ZERO)) && (rs == ex_mem_rd)) begin
            sel = FWD_MEM;
        end else if (mem_wb_regwrite && (mem_wb_rd != REG_AW'(REG_ZERO)) && (rs == mem_wb_rd)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller: per-source forwarding selects plus load-use / multi-cycle stall engine.
// Latency: forwarding and first-cycle stalls are combinational; engine state updates each clk.
// Backpressure: stall_if/stall_id hold the front end, hold_ex freezes EX while MUL/DIV is busy.
//
// Ports: id_* decode sources, ex_rs / *_rd / *_regwrite pipeline fields, mc_start,
// outputs fwd_sel (2 bits per source), stall_if, stall_id, bubble_ex, hold_ex, mc_busy.
// Optional macro HAZARD_FWD_STATS_EN adds stat_lu_stalls, stat_mc_cycles, stat_fwd_events.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int MC_LAT     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0]         id_ex_rd,
    input  logic                      id_ex_regwrite,
    input  logic                      id_ex_memread,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      ex_mem_regwrite,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      mem_wb_regwrite,
    input  logic                      mc_start,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      bubble_ex,
    output logic                      hold_ex,
    output logic                      mc_busy
`ifdef HAZARD_FWD_STATS_EN
    ,
    output logic [31:0]               stat_lu_stalls,
    output logic [31:0]               stat_mc_cycles,
    output logic [31:0]               stat_fwd_events
`endif
);

    localparam int MC_W = $clog2(MC_LAT) + 1;
    localparam int LD_W = $clog2(LOAD_STALL) + 1;

    hz_state_e         state_q, state_d;
    logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic [NUM_SRC-1:0] src_hit;
    logic              lu;
    fwd_sel_e          lane_sel [NUM_SRC];

    // Forwarding lanes and load-use source compare, one per source operand.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_sel_lane #(.REG_AW(REG_AW)) u_lane (
            .rs              (ex_rs[i*REG_AW +: REG_AW]),
            .ex_mem_rd       (ex_mem_rd),
            .ex_mem_regwrite (ex_mem_regwrite),
            .mem_wb_rd       (mem_wb_rd),
            .mem_wb_regwrite (mem_wb_regwrite),
            .sel             (lane_sel[i])
        );
        assign fwd_sel[2*i +: 2] = rst ? FWD_RF : lane_sel[i];
        assign src_hit[i]        = (id_rs[i*REG_AW +: REG_AW] == id_ex_rd);
    end

    assign lu = id_valid && id_ex_memread && id_ex_regwrite &&
                (id_ex_rd != REG_AW'(REG_ZERO)) && (|src_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HZ_IDLE;
            mc_cnt_q <= '0;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    // The detect/start cycle in IDLE already counts as the first stall or busy
    // cycle, so both counters hold "cycles still to go after this one" and the
    // engine leaves its state on the cycle where that reaches one. A single-cycle
    // load stall is fully covered by the detect cycle and never enters LOAD_STALL.
    always_comb begin
        state_d   = state_q;
        mc_cnt_d  = mc_cnt_q;
        ld_cnt_d  = ld_cnt_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        hold_ex   = 1'b0;
        mc_busy   = 1'b0;
        case (state_q)
            HZ_IDLE: begin
                if (mc_start) begin
                    state_d  = HZ_MC_BUSY;
                    mc_cnt_d = MC_W'(MC_LAT - 1);
                    mc_busy  = 1'b1;
                    hold_ex  = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end else if (lu) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    ld_cnt_d  = LD_W'(LOAD_STALL - 1);
                    if (LOAD_STALL > 1) begin
                        state_d = HZ_LOAD_STALL;
                    end
                end
            end
            HZ_LOAD_STALL: begin
                // ID/EX already carries the NOP inserted on the detect cycle.
                stall_if = 1'b1;
                stall_id = 1'b1;
                if (ld_cnt_q <= LD_W'(1)) begin
                    state_d  = HZ_IDLE;
                    ld_cnt_d = '0;
                end else begin
                    ld_cnt_d = ld_cnt_q - LD_W'(1);
                end
            end
            HZ_MC_BUSY: begin
                mc_busy  = 1'b1;
                hold_ex  = 1'b1;
                stall_if = 1'b1;
                stall_id = 1'b1;
                mc_cnt_d = mc_cnt_q - MC_W'(1);
                if (mc_cnt_q <= MC_W'(1)) begin
                    state_d = HZ_IDLE;
                end
            end
            default: begin
                state_d = HZ_IDLE;
            end
        endcase
        // Reset drops every stall immediately rather than on the next edge.
        if (rst) begin
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            bubble_ex = 1'b0;
            hold_ex   = 1'b0;
            mc_busy   = 1'b0;
        end
    end

`ifdef HAZARD_FWD_STATS_EN
    logic [2:0] fwd_cnt;

    always_comb begin
        fwd_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fwd_sel[2*i +: 2] != 2'b00) begin
                fwd_cnt = fwd_cnt + 3'd1;
            end
        end
    end

    // A load-use stall cycle is any front-end stall not owned by the MC unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lu_stalls  <= '0;
            stat_mc_cycles  <= '0;
            stat_fwd_events <= '0;
        end else begin
            stat_lu_stalls  <= sat_add32(stat_lu_stalls, {2'b0, stall_id && !mc_busy});
            stat_mc_cycles  <= sat_add32(stat_mc_cycles, {2'b0, mc_busy});
            stat_fwd_events <= sat_add32(stat_fwd_events, fwd_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl (REG_AW=5, NUM_SRC=2, LOAD_STALL=2, MC_LAT=4).
// Table of forwarding vectors plus hand-written stall sequences.
// Control outputs are checked as {stall_if, stall_id, bubble_ex, hold_ex, mc_busy}.
module tb_hazard_fwd_ctrl;

    localparam int AW = 5;
    localparam int NS = 2;
    localparam int LS = 2;
    localparam int ML = 4;

    localparam logic [4:0] C_IDLE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11100;
    localparam logic [4:0] C_LS   = 5'b11000;
    localparam logic [4:0] C_MC   = 5'b11011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NS*AW-1:0] id_rs;
    logic            id_valid;
    logic [NS*AW-1:0] ex_rs;
    logic [AW-1:0]   id_ex_rd;
    logic            id_ex_regwrite;
    logic            id_ex_memread;
    logic [AW-1:0]   ex_mem_rd;
    logic            ex_mem_regwrite;
    logic [AW-1:0]   mem_wb_rd;
    logic            mem_wb_regwrite;
    logic            mc_start;
    logic [NS*2-1:0] fwd_sel;
    logic            stall_if, stall_id, bubble_ex, hold_ex, mc_busy;
`ifdef HAZARD_FWD_STATS_EN
    logic [31:0]     stat_lu_stalls, stat_mc_cycles, stat_fwd_events;
`endif

    logic [4:0] ctl;
    assign ctl = {stall_if, stall_id, bubble_ex, hold_ex, mc_busy};

    hazard_fwd_ctrl #(
        .REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL(LS), .MC_LAT(ML)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_valid        (id_valid),
        .ex_rs           (ex_rs),
        .id_ex_rd        (id_ex_rd),
        .id_ex_regwrite  (id_ex_regwrite),
        .id_ex_memread   (id_ex_memread),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mc_start        (mc_start),
        .fwd_sel         (fwd_sel),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .hold_ex         (hold_ex),
        .mc_busy         (mc_busy)
`ifdef HAZARD_FWD_STATS_EN
        ,
        .stat_lu_stalls  (stat_lu_stalls),
        .stat_mc_cycles  (stat_mc_cycles),
        .stat_fwd_events (stat_fwd_events)
`endif
    );

    typedef struct {
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [4:0] mrd;
        logic       mrw;
        logic [4:0] wrd;
        logic       wrw;
        logic [3:0] exp_sel;
    } fvec_t;

    fvec_t vecs [8];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs           = '0;
        id_valid        = 1'b0;
        ex_rs           = '0;
        id_ex_rd        = '0;
        id_ex_regwrite  = 1'b0;
        id_ex_memread   = 1'b0;
        ex_mem_rd       = '0;
        ex_mem_regwrite = 1'b0;
        mem_wb_rd       = '0;
        mem_wb_regwrite = 1'b0;
        mc_start        = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load in ID/EX writing r7 while decode reads r7 as source 1.
    task automatic set_load_use();
        id_valid       = 1'b1;
        id_ex_memread  = 1'b1;
        id_ex_regwrite = 1'b1;
        id_ex_rd       = 5'd7;
        id_rs          = {5'd7, 5'd2};
    endtask

    initial begin
        vecs[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 5'd5,  1'b1, 4'b0010};
        vecs[1] = '{5'd5,  5'd0,  5'd5,  1'b0, 5'd5,  1'b1, 4'b0001};
        vecs[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 4'b0000};
        vecs[3] = '{5'd3,  5'd9,  5'd9,  1'b1, 5'd3,  1'b1, 4'b1001};
        vecs[4] = '{5'd3,  5'd3,  5'd3,  1'b0, 5'd3,  1'b0, 4'b0000};
        vecs[5] = '{5'd31, 5'd31, 5'd31, 1'b1, 5'd4,  1'b1, 4'b1010};
        vecs[6] = '{5'd4,  5'd31, 5'd30, 1'b1, 5'd4,  1'b1, 4'b0001};
        vecs[7] = '{5'd12, 5'd12, 5'd12, 1'b0, 5'd12, 1'b1, 4'b0101};

        // Reset: matching forwarding inputs must still give 00 while rst is high.
        idle_inputs();
        rst             = 1'b1;
        ex_rs           = {5'd5, 5'd5};
        ex_mem_rd       = 5'd5;
        ex_mem_regwrite = 1'b1;
        mc_start        = 1'b1;
        step();
        step();
        #2;
        check("reset_ctl", 32'(ctl), 32'(C_IDLE));
        check("reset_fwd", 32'(fwd_sel), 32'h0);
        idle_inputs();
        rst = 1'b0;
        step();
        check("post_reset_ctl", 32'(ctl), 32'(C_IDLE));

        // Forwarding table.
        for (int i = 0; i < 8; i++) begin
            ex_rs           = {vecs[i].rs1, vecs[i].rs0};
            ex_mem_rd       = vecs[i].mrd;
            ex_mem_regwrite = vecs[i].mrw;
            mem_wb_rd       = vecs[i].wrd;
            mem_wb_regwrite = vecs[i].wrw;
            #2;
            check($sformatf("fwd_vec%0d", i), 32'(fwd_sel), 32'(vecs[i].exp_sel));
            check($sformatf("fwd_vec%0d_ctl", i), 32'(ctl), 32'(C_IDLE));
        end
        idle_inputs();

        // Non-hazards: x0 destination, invalid decode slot, not a load.
        for (int k = 0; k < 3; k++) begin
            set_load_use();
            if (k == 0) begin
                id_ex_rd = 5'd0;
                id_rs    = {5'd0, 5'd0};
            end
            if (k == 1) id_valid = 1'b0;
            if (k == 2) id_ex_memread = 1'b0;
            #2;
            check($sformatf("no_lu_case%0d", k), 32'(ctl), 32'(C_IDLE));
        end
        idle_inputs();
        step();

        // Load-use, two stall cycles, bubble only on the first.
        set_load_use();
        #2;
        check("lu_cyc1", 32'(ctl), 32'(C_LU));
        step();
        id_ex_memread = 1'b0;
        id_ex_rd      = 5'd0;
        #2;
        check("lu_cyc2", 32'(ctl), 32'(C_LS));
        step();
        #2;
        check("lu_done", 32'(ctl), 32'(C_IDLE));
        idle_inputs();

        // mc_start during LOAD_STALL is ignored.
        step();
        set_load_use();
        #2;
        check("lu_mcign_cyc1", 32'(ctl), 32'(C_LU));
        step();
        idle_inputs();
        mc_start = 1'b1;
        #2;
        check("lu_mcign_cyc2", 32'(ctl), 32'(C_LS));
        step();
        mc_start = 1'b0;
        #2;
        check("lu_mcign_done", 32'(ctl), 32'(C_IDLE));

        // Multi-cycle op: exactly four busy cycles.
        step();
        mc_start = 1'b1;
        for (int c = 0; c < ML; c++) begin
            #2;
            check($sformatf("mc_cyc%0d", c), 32'(ctl), 32'(C_MC));
            step();
            mc_start = 1'b0;
        end
        #2;
        check("mc_done", 32'(ctl), 32'(C_IDLE));

        // mc_start together with load-use: MC wins, the held hazard stalls after.
        step();
        set_load_use();
        mc_start = 1'b1;
        for (int c = 0; c < ML; c++) begin
            #2;
            check($sformatf("mc_lu_cyc%0d", c), 32'(ctl), 32'(C_MC));
            step();
            mc_start = 1'b0;
        end
        #2;
        check("mc_lu_then_lu", 32'(ctl), 32'(C_LU));
        step();
        id_ex_memread = 1'b0;
        #2;
        check("mc_lu_then_ls", 32'(ctl), 32'(C_LS));
        step();
        #2;
        check("mc_lu_done", 32'(ctl), 32'(C_IDLE));
        idle_inputs();

        // Reset in the second busy cycle, then a fresh op is honoured.
        step();
        mc_start = 1'b1;
        #2;
        check("rst_mid_cyc1", 32'(ctl), 32'(C_MC));
        step();
        mc_start = 1'b0;
        rst      = 1'b1;
        #2;
        check("rst_mid_drop", 32'(ctl), 32'(C_IDLE));
        step();
        rst = 1'b0;
        #2;
        check("rst_mid_idle", 32'(ctl), 32'(C_IDLE));
        step();
        mc_start = 1'b1;
        for (int c = 0; c < ML; c++) begin
            #2;
            check($sformatf("rst_mc_cyc%0d", c), 32'(ctl), 32'(C_MC));
            step();
            mc_start = 1'b0;
        end
        #2;
        check("rst_mc_done", 32'(ctl), 32'(C_IDLE));

`ifdef HAZARD_FWD_STATS_EN
        // Three load-use events (two stall cycles each here) plus one MC op.
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        check("stat_lu_reset", stat_lu_stalls, 32'd0);
        for (int e = 0; e < 3; e++) begin
            set_load_use();
            step();
            idle_inputs();
            step();
            step();
        end
        mc_start = 1'b1;
        step();
        mc_start = 1'b0;
        repeat (ML) step();
        #2;
        check("stat_lu_stalls", stat_lu_stalls, 32'(3 * LS));
        check("stat_mc_cycles", stat_mc_cycles, 32'(ML));
        check("stat_fwd_none", stat_fwd_events, 32'd0);
        // Both sources forwarding for two cycles.
        ex_rs           = {5'd9, 5'd9};
        ex_mem_rd       = 5'd9;
        ex_mem_regwrite = 1'b1;
        step();
        step();
        idle_inputs();
        #2;
        check("stat_fwd_events", stat_fwd_events, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
